// File: rtl/ula_muldiv.sv
// ula_muldiv: iterative multiply/divide unit with private HI/LO registers.
//
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring), one bit per clock.
// A launched operation spends WIDTH cycles in CALC and then one cycle in DONE.
// MTHI/MTLO writes are accepted only while idle.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-high reset, clears all state
//   start            launch the operation selected by op (sampled in IDLE only)
//   op[1:0]          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   In1, In2         rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   mthi, mtlo       write wdata to HI / LO (IDLE only, start has priority)
//   wdata            data for mthi/mtlo
//   busy             operation in progress (CALC)
//   done             one-cycle pulse, HI/LO just updated
//   div_zero         last divide had a zero divisor; cleared by the next start
//   hi, lo           HI / LO result registers
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;   // product / quotient must be negated
  logic               neg_rem;   // remainder takes the dividend's (negative) sign
  logic               dz;        // divisor was zero
  logic [WIDTH-1:0]   in1_raw;   // unmodified dividend for the divide-by-zero result
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
  // Multiply: {partial product upper, remaining multiplier bits / product lower}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc;

  // Magnitude of a value, interpreted as signed only when sgn is set.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Launch-time operand preparation
  logic             ld_signed;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             sign_diff;

  always_comb begin
    ld_signed = ~op[0];
    mag1      = mag(In1, ld_signed);
    mag2      = mag(In2, ld_signed);
    sign_diff = ld_signed & (In1[WIDTH-1] ^ In2[WIDTH-1]);
  end

  // One iteration step for both algorithms
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    addend  = acc[0] ? opnd : '0;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Partial remainder < divisor, so the shifted value fits in WIDTH+1 bits
    // and bit WIDTH of the difference is the borrow.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    if (!rem_diff[WIDTH])
      div_nxt = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    acc_nxt  = is_div ? div_nxt : mul_nxt;
    prod_fix = neg2_if(acc_nxt, neg_res);
    quo_fix  = neg_if(acc_nxt[WIDTH-1:0], neg_res);
    rem_fix  = neg_if(acc_nxt[2*WIDTH-1:WIDTH], neg_rem);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      in1_raw  <= '0;
      opnd     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            in1_raw  <= In1;
            neg_res  <= sign_diff;
            cnt      <= CNT_W'(WIDTH - 1);
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= CALC;
            if (op[1]) begin
              opnd    <= mag2;
              acc     <= {{WIDTH{1'b0}}, mag1};
              neg_rem <= ld_signed & In1[WIDTH-1];
              dz      <= (In2 == '0);
            end else begin
              opnd    <= mag1;
              acc     <= {{WIDTH{1'b0}}, mag2};
              neg_rem <= 1'b0;
              dz      <= 1'b0;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end

        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Sign fixup and HI/LO write on the final iteration edge
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (dz) begin
              hi       <= in1_raw;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv.sv
// Testbench for ula_muldiv: table of directed vectors, random vectors checked
// against a behavioural model, and hand-written handshake/reset sequences.
module tb_ula_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  ula_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .In1(in1), .In2(in2),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Behavioural reference built on SystemVerilog arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sp;
    logic [63:0] up;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {e.hi, e.lo} = sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {e.hi, e.lo} = up;
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (o == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
          end else begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
          end
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Launch one operation, optionally inject a stray start (kind 0) or mtlo
  // (kind 1) at CALC cycle inj_at, then wait for done and score the result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int inj_at, input int inj_kind,
                        input logic with_mtlo);
    int edges;
    int bcyc;
    exp_t got;
    logic [31:0] hold_hi, hold_lo;
    @(negedge clk);
    op = o; in1 = a; in2 = b; start = 1'b1;
    mtlo = with_mtlo; wdata = 32'h0BAD_F00D;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    check("dz_clear_on_start", {63'd0, div_zero}, 64'd0);
    edges = 1;
    bcyc  = busy;
    while (!done && edges < 200) begin
      if (edges == inj_at) begin
        if (inj_kind == 0) begin
          start = 1'b1; op = ~o; in1 = 32'h1357_9BDF; in2 = 32'h0000_0005;
        end else begin
          mtlo = 1'b1; wdata = 32'hCAFE_0001;
        end
      end
      @(posedge clk); #1;
      start = 1'b0; mtlo = 1'b0;
      edges++;
      bcyc += busy;
    end
    got = sb.size() > 0 ? sb.pop_front() : '0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done after %0d edges, required done", edges);
    end else begin
      // Edges counted from the start edge inclusive.
      check("latency_edges", 64'(edges), 64'd33);
      check("busy_cycles",   64'(bcyc),  64'd32);
      check("busy_in_done",  {63'd0, busy}, 64'd0);
      check("hi",  {32'd0, hi}, {32'd0, got.hi});
      check("lo",  {32'd0, lo}, {32'd0, got.lo});
      check("div_zero", {63'd0, div_zero}, {63'd0, got.dz});
      hold_hi = got.hi;
      hold_lo = got.lo;
      @(posedge clk); #1;
      check("done_pulse", {63'd0, done}, 64'd0);
      check("hold", {hi, lo}, {hold_hi, hold_lo});
    end
  endtask

  exp_t x;
  logic [1:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0}};
    tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}};
    tbl[2] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, '{32'h0000_0006, 32'hFFFF_FFEB, 1'b0}};
    tbl[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}};
    tbl[4] = '{2'b11, 32'd100,       32'd7,         '{32'd2,         32'd14,        1'b0}};
    tbl[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0000_0000, 32'h8000_0000, 1'b0}};
    tbl[6] = '{2'b11, 32'h0000_1234, 32'h0000_0000, '{32'h0000_1234, 32'hFFFF_FFFF, 1'b1}};
    tbl[7] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1}};

    // Reset state
    #23 reset = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz",   {63'd0, div_zero}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    // mthi / mtlo in IDLE
    @(negedge clk); mthi = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1; mthi = 1'b0;
    check("mthi", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_0F0F;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h5A5A_0F0F, 32'h5A5A_0F0F});

    // Directed table
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, -1, 0, 1'b0);

    // div_zero holds after a zero divide until the next start
    run_op(2'b11, 32'h0000_1234, 32'd0, tbl[6].e, -1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("dz_hold", {63'd0, div_zero}, 64'd1);
    x = model(2'b01, 32'd3, 32'd5);
    run_op(2'b01, 32'd3, 32'd5, x, -1, 0, 1'b0);

    // Stray start at CALC cycle 10 is ignored
    x = model(2'b00, 32'h0001_2345, 32'hFFFF_0010);
    run_op(2'b00, 32'h0001_2345, 32'hFFFF_0010, x, 10, 0, 1'b0);
    // mtlo during CALC is ignored
    x = model(2'b11, 32'hDEAD_BEEF, 32'h0000_1001);
    run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1001, x, 12, 1, 1'b0);
    // start + mtlo together: start wins
    x = model(2'b01, 32'd9, 32'd11);
    run_op(2'b01, 32'd9, 32'd11, x, -1, 0, 1'b1);

    // Random vectors against the model
    for (int i = 0; i < 8; i++) begin
      rop = 2'(i);
      ra  = $urandom;
      rb  = (i % 4 == 3) ? 32'($urandom_range(1, 65535)) : $urandom;
      x   = model(rop, ra, rb);
      run_op(rop, ra, rb, x, -1, 0, 1'b0);
    end

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    op = 2'b01; in1 = 32'hFFFF_FFFF; in2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); #2 reset = 1'b0;
    x = '{32'd0, 32'd42, 1'b0};
    run_op(2'b01, 32'd6, 32'd7, x, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
